mem_port_arbiter: RTL and testbench

- Shares the multicycle CPU's single unified memory port between two requesters: M0 is the CPU (instruction fetch and load/store), M1 is a DMA/debug loader.
- Each request is one complete access. The block serialises accesses, drives the memory address/write/data lines and returns a one-cycle acknowledge with read data.
- The CPU control FSM stalls on m0_req && !m0_ack.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single unified memory port (M0 = CPU, M1 = DMA/debug).
// Define MEM_ARB_FIXED_PRIO_EN for fixed M0 priority; otherwise ties resolve round-robin.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LP_WAIT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_cmd_we;

  logic        w_m0_elig;
  logic        w_m1_elig;
  logic        w_grant;
  logic        w_pick;

  // A requester is masked in its own ack cycle so its stale req is not re-granted.
  assign w_m0_elig = m0_req & ~m0_ack;
  assign w_m1_elig = m1_req & ~m1_ack;
  assign w_grant   = w_m0_elig | w_m1_elig;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_pick = ~w_m0_elig;
`else
  logic r_last;

  assign w_pick = (w_m0_elig & w_m1_elig) ? ~r_last : w_m1_elig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE && w_grant) begin
      r_last <= w_pick;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_cmd_we  <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_adr   <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      mem_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            owner     <= w_pick;
            r_cmd_we  <= w_pick ? m1_we : m0_we;
            mem_we    <= w_pick ? m1_we : m0_we;
            mem_adr   <= w_pick ? m1_adr : m0_adr;
            mem_wdata <= w_pick ? m1_wdata : m0_wdata;
            busy      <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cmd_we) begin
            m0_ack  <= ~owner;
            m1_ack  <= owner;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (MEM_LAT > 1) begin
            r_cnt   <= LP_WAIT_INIT;
            r_state <= WAIT;
          end else begin
            r_state <= RESP;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (owner) begin
            m1_rdata <= mem_rdata;
            m1_ack   <= 1'b1;
          end else begin
            m0_rdata <= mem_rdata;
            m0_ack   <= 1'b1;
          end
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1..3) share one stimulus; a
// timestamp-based transaction model predicts every output each cycle, plus literal checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_adr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_adr = '0, m1_wdata = '0;

  wire [2:0]       ack0, ack1, mwe, own, bsy;
  wire [2:0][31:0] rd0, rd1, madr, mwd;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h12345678;
    return 32'hA5000000 + 32'(i) * 32'h00010203;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L = gi + 1;
    logic [31:0] dmem [64];
    logic [31:0] pipe [L];
    logic [31:0] mrd;

    initial for (int i = 0; i < 64; i++) dmem[i] = init_word(i);

    // Memory returns the word addressed L cycles earlier.
    always @(posedge clk) begin
      if (mwe[gi]) dmem[madr[gi][7:2]] <= mwd[gi];
      pipe[0] <= dmem[madr[gi][7:2]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mrd = pipe[L-1];

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
      .m0_ack(ack0[gi]), .m0_rdata(rd0[gi]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
      .m1_ack(ack1[gi]), .m1_rdata(rd1[gi]),
      .mem_adr(madr[gi]), .mem_we(mwe[gi]), .mem_wdata(mwd[gi]), .mem_rdata(mrd),
      .owner(own[gi]), .busy(bsy[gi])
    );
  end

  // Transaction model: each grant fixes when the port frees up and what the outputs become.
  logic [31:0] mm [3][64];
  logic [31:0] e_adr [3], e_wd [3], e_rd0 [3], e_rd1 [3], rd_val [3];
  logic        e_own [3], last [3], ack_who [3], ack_v [3], ack_rd [3];
  int          ack_cyc [3], we_cyc [3];

  initial for (int k = 0; k < 3; k++) for (int i = 0; i < 64; i++) mm[k][i] = init_word(i);

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic ea, e0, e1, w, wr;
      logic [31:0] a, d;
      if (!rst) begin
        e_adr[k] = '0; e_wd[k] = '0; e_rd0[k] = '0; e_rd1[k] = '0;
        e_own[k] = 1'b0; last[k] = 1'b1; ack_v[k] = 1'b0; ack_who[k] = 1'b0;
        ack_rd[k] = 1'b0; ack_cyc[k] = 0; we_cyc[k] = -1;
      end else if (ack_v[k] && cyc == ack_cyc[k] && ack_rd[k]) begin
        if (ack_who[k]) e_rd1[k] = rd_val[k];
        else            e_rd0[k] = rd_val[k];
      end
      ea = ack_v[k] && (cyc == ack_cyc[k]);
      chk("m0_ack", k, 32'(ack0[k]), 32'(ea && !ack_who[k]));
      chk("m1_ack", k, 32'(ack1[k]), 32'(ea && ack_who[k]));
      chk("m0_rdata", k, rd0[k], e_rd0[k]);
      chk("m1_rdata", k, rd1[k], e_rd1[k]);
      chk("mem_adr", k, madr[k], e_adr[k]);
      chk("mem_wdata", k, mwd[k], e_wd[k]);
      chk("mem_we", k, 32'(mwe[k]), 32'(cyc == we_cyc[k]));
      chk("owner", k, 32'(own[k]), 32'(e_own[k]));
      chk("busy", k, 32'(bsy[k]), 32'(ack_v[k] && cyc < ack_cyc[k]));
      if (rst && cyc >= ack_cyc[k]) begin
        e0 = m0_req && !(ea && !ack_who[k]);
        e1 = m1_req && !(ea && ack_who[k]);
        if (e0 || e1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          w = !e0;
`else
          w = (e0 && e1) ? !last[k] : e1;
`endif
          wr = w ? m1_we : m0_we;
          a  = w ? m1_adr : m0_adr;
          d  = w ? m1_wdata : m0_wdata;
          last[k] = w; e_own[k] = w; e_adr[k] = a; e_wd[k] = d;
          ack_v[k] = 1'b1; ack_who[k] = w; ack_rd[k] = !wr;
          ack_cyc[k] = cyc + (wr ? 2 : k + 3);
          we_cyc[k] = wr ? cyc + 1 : -1;
          if (wr) mm[k][a[7:2]] = d;
          else    rd_val[k] = mm[k][a[7:2]];
        end
      end
    end
  end

  task automatic go(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic to_neg(input int c);
    go(c);
    @(negedge clk);
  endtask

  initial begin
    int t;
    go(3);
    rst = 1'b1;
    go(6);

    // M0 single-cycle read of 0x10
    t = cyc; m0_req = 1; m0_we = 0; m0_adr = 32'h10;
    go(t + 1); m0_req = 0;
    to_neg(t + 1); chk("A_adr", 0, madr[0], 32'h10); chk("A_we", 0, 32'(mwe[0]), 0);
    to_neg(t + 2); chk("A_noack", 0, 32'(ack0[0]), 0);
    to_neg(t + 3); chk("A_ack", 0, 32'(ack0[0]), 1); chk("A_rdata", 0, rd0[0], 32'h12345678);
    to_neg(t + 4); chk("A_ack_l2", 1, 32'(ack0[1]), 1);
    to_neg(t + 5); chk("A_nogrant_l2", 1, 32'(bsy[1]), 0);
    go(t + 12);

    // M1 write 0xDEADBEEF to 0x20
    t = cyc; m1_req = 1; m1_we = 1; m1_adr = 32'h20; m1_wdata = 32'hDEADBEEF;
    go(t + 1); m1_req = 0; m1_wdata = 32'h0BADF00D;
    to_neg(t + 1); chk("B_we", 0, 32'(mwe[0]), 1); chk("B_adr", 0, madr[0], 32'h20);
    chk("B_wdata", 0, mwd[0], 32'hDEADBEEF); chk("B_owner", 0, 32'(own[0]), 1);
    to_neg(t + 2); chk("B_ack", 0, 32'(ack1[0]), 1); chk("B_we_off", 0, 32'(mwe[0]), 0);
    chk("B_rd1_kept", 0, rd1[0], 32'h0);
    go(t + 12);

    // M1 reads back 0x20 (MEM_LAT=3 instance)
    t = cyc; m1_req = 1; m1_we = 0;
    go(t + 1); m1_req = 0;
    to_neg(t + 4); chk("C_noack", 2, 32'(ack1[2]), 0);
    to_neg(t + 5); chk("C_ack", 2, 32'(ack1[2]), 1); chk("C_rdata", 2, rd1[2], 32'hDEADBEEF);
    go(t + 12);

    // Contention: both hold read requests
    t = cyc; m0_req = 1; m0_adr = 32'h04; m1_req = 1; m1_adr = 32'h08;
    to_neg(t + 1); chk("D_own0", 0, 32'(own[0]), 0);
    to_neg(t + 3); chk("D_ack0", 0, 32'(ack0[0]), 1); chk("D_noack1", 0, 32'(ack1[0]), 0);
    to_neg(t + 4); chk("D_own1", 0, 32'(own[0]), 1);
    to_neg(t + 6); chk("D_ack1", 0, 32'(ack1[0]), 1);
    to_neg(t + 9); chk("D_ack0b", 0, 32'(ack0[0]), 1);
    go(t + 12); m0_req = 0; m1_req = 0;
    go(t + 24);

    // Late arrival of M1 during an M0 read
    t = cyc; m0_req = 1; m0_adr = 32'h0C; m1_adr = 32'h30;
    go(t + 1); m0_req = 0;
    go(t + 2); m1_req = 1;
    to_neg(t + 5); chk("E_ack0", 2, 32'(ack0[2]), 1);
    to_neg(t + 6); chk("E_adr", 2, madr[2], 32'h30); chk("E_own", 2, 32'(own[2]), 1);
    go(t + 8); m1_req = 0;
    go(t + 20);

    // Reset during a read's WAIT state, then a tie after release
    t = cyc; m0_req = 1; m0_adr = 32'h10;
    go(t + 1); m0_req = 0;
    go(t + 2); rst = 1'b0;
    to_neg(t + 2); chk("F_ack", 2, 32'(ack0[2]), 0); chk("F_busy", 2, 32'(bsy[2]), 0);
    chk("F_we", 2, 32'(mwe[2]), 0); chk("F_adr", 2, madr[2], 0); chk("F_rd0", 2, rd0[2], 0);
    go(t + 4); rst = 1'b1;
    m0_req = 1; m0_adr = 32'h14; m1_req = 1; m1_adr = 32'h18;
    go(t + 5); m0_req = 0; m1_req = 0;
    to_neg(t + 5); chk("G_own", 0, 32'(own[0]), 0); chk("G_adr", 0, madr[0], 32'h14);
    to_neg(t + 8); chk("G_ack_l2", 1, 32'(ack0[1]), 1);
    go(t + 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
